// File: rtl/multicycle_control.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/MULDIV sequencer with state-decoded controls.
// Optional feature macro CU_ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP until reset.
module multicycle_control #(
  parameter int ALU_OP_W      = 3,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_code,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                reg_dst,
  output logic                jump,
  output logic                beq,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_write,
  output logic                ir_write,
  output logic                hilo_write,
  output logic                busy,
  output logic                illegal
);

  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_NOR  = 6'b100101;
  localparam logic [5:0] OP_ADD  = 6'b100111;
  localparam logic [5:0] OP_SUB  = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_DIV  = 6'b101010;
  localparam logic [5:0] OP_MULT = 6'b011010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_MFHI = 6'b011000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV
`ifdef CU_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t     state, nxt;
  logic [5:0] opc;
  logic [7:0] cnt;
  logic [2:0] code;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_ADDI, OP_DIV,
      OP_MULT, OP_LW, OP_SW, OP_MFHI, OP_MFLO, OP_BEQ, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // MFHI/MFLO fall to the default so the ALU sees 000
  function automatic logic [2:0] alu_code(input logic [5:0] op);
    case (op)
      OP_OR:                         alu_code = 3'b001;
      OP_NOR:                        alu_code = 3'b010;
      OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_code = 3'b011;
      OP_SUB, OP_BEQ:                alu_code = 3'b100;
      OP_SLT:                        alu_code = 3'b101;
      OP_MULT:                       alu_code = 3'b110;
      OP_DIV:                        alu_code = 3'b111;
      default:                       alu_code = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      opc   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) opc <= op_code;
      if (state == S_EXEC && nxt == S_MULDIV) cnt <= 8'(MULDIV_CYCLES - 1);
      else if (state == S_MULDIV && cnt != 8'd0) cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    nxt        = state;
    code       = 3'b000;
    reg_dst    = 1'b0;
    jump       = 1'b0;
    beq        = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    hilo_write = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        nxt      = S_DECODE;
      end
      S_DECODE: begin
        if (op_code == OP_J) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          nxt      = S_FETCH;
        end else if (!is_legal(op_code)) begin
          illegal = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          nxt = S_TRAP;
`else
          nxt = S_FETCH;
`endif
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        code    = alu_code(opc);
        alu_src = (opc == OP_ADDI) || (opc == OP_LW) || (opc == OP_SW);
        case (opc)
          OP_BEQ: begin
            beq      = 1'b1;
            pc_write = zero;
            nxt      = S_FETCH;
          end
          OP_LW, OP_SW:    nxt = S_MEM;
          OP_MULT, OP_DIV: nxt = S_MULDIV;
          default:         nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (opc == OP_LW);
        mem_write = (opc != OP_LW);
        if (mem_ready) nxt = (opc == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = !((opc == OP_ADDI) || (opc == OP_LW));
        mem_to_reg = (opc == OP_LW);
        nxt        = S_FETCH;
      end
      S_MULDIV: begin
        if (cnt == 8'd0) begin
          hilo_write = 1'b1;
          nxt        = S_FETCH;
        end
      end
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: nxt = S_FETCH;
    endcase
    alu_op      = '0;
    alu_op[2:0] = code;
    busy        = (state != S_FETCH);
    // The reset cycle sits in FETCH; keep its strobes quiet until rst drops
    if (rst) begin
      reg_dst    = 1'b0;
      jump       = 1'b0;
      beq        = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      hilo_write = 1'b0;
      illegal    = 1'b0;
      busy       = 1'b0;
      alu_op     = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle tables from the opcode rules,
// checked every cycle by an independent monitor.
module tb_multicycle_control;
  localparam int AW  = 5;
  localparam int NMD = 4;

  localparam logic [5:0] AND_ = 6'b000000, OR_ = 6'b010000, NOR_ = 6'b100101, ADD_ = 6'b100111;
  localparam logic [5:0] SUB_ = 6'b100000, SLT_ = 6'b100010, ADDI_ = 6'b001000, DIV_ = 6'b101010;
  localparam logic [5:0] MULT_ = 6'b011010, LW_ = 6'b100011, SW_ = 6'b101011, MFHI_ = 6'b011000;
  localparam logic [5:0] MFLO_ = 6'b010010, BEQ_ = 6'b000100, J_ = 6'b000010;

  typedef struct packed {
    logic reg_dst, jump, beq, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic pc_write, ir_write, hilo_write, busy, illegal;
    logic [AW-1:0] alu_op;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op_code = '0;
  logic reg_dst, jump, beq, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic pc_write, ir_write, hilo_write, busy, illegal;
  logic [AW-1:0] alu_op;

  vec_t exp_q[$];
  vec_t act, e_mon;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_OP_W(AW), .MULDIV_CYCLES(NMD)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .reg_dst(reg_dst), .jump(jump), .beq(beq), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .pc_write(pc_write), .ir_write(ir_write), .hilo_write(hilo_write), .busy(busy),
    .illegal(illegal)
  );

  assign act = {reg_dst, jump, beq, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
                pc_write, ir_write, hilo_write, busy, illegal, alu_op};

  initial forever begin
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      n_cmp++;
      if (act !== e_mon) begin
        n_bad++;
        $display("FAIL outputs cycle=%0d actual=%h expected=%h", cyc, act, e_mon);
      end
    end
  end

  function automatic bit legal(input logic [5:0] op);
    return op inside {AND_, OR_, NOR_, ADD_, SUB_, SLT_, ADDI_, DIV_, MULT_, LW_, SW_,
                      MFHI_, MFLO_, BEQ_, J_};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] op);
    if (op == OR_) return 3'd1;
    if (op == NOR_) return 3'd2;
    if (op inside {ADD_, ADDI_, LW_, SW_}) return 3'd3;
    if (op inside {SUB_, BEQ_}) return 3'd4;
    if (op == SLT_) return 3'd5;
    if (op == MULT_) return 3'd6;
    if (op == DIV_) return 3'd7;
    return 3'd0;
  endfunction

  task automatic step(input bit r, input logic [5:0] op, input bit z, input bit mr, input vec_t e);
    @(posedge clk); #1;
    rst = r; op_code = op; zero = z; mem_ready = mr;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle outputs for one instruction; abort_at = cycle index that asserts rst
  task automatic instr(input logic [5:0] op, input bit z, input int waits, input int abort_at);
    vec_t seq[$];
    vec_t v;
    int   ex = -1, m0 = -1, m1 = -1;
    bit   lw = (op == LW_), sw = (op == SW_), md = (op == MULT_ || op == DIV_);
    v = '0; v.ir_write = 1; v.pc_write = 1; seq.push_back(v);
    v = '0; v.busy = 1;
    if (op == J_) begin
      v.jump = 1; v.pc_write = 1; seq.push_back(v);
    end else if (!legal(op)) begin
      v.illegal = 1; seq.push_back(v);
`ifdef CU_ILLEGAL_TRAP_EN
      for (int i = 0; i <= waits; i++) seq.push_back(v);
      if (abort_at < 0 || abort_at > seq.size()) abort_at = seq.size();
`endif
    end else begin
      seq.push_back(v);
      ex = 2;
      v = '0; v.busy = 1; v.alu_op = AW'(alu_ref(op));
      v.alu_src = (op == ADDI_) || lw || sw;
      if (op == BEQ_) begin v.beq = 1; v.pc_write = z; end
      seq.push_back(v);
      if (lw || sw) begin
        m0 = seq.size(); m1 = m0 + waits;
        for (int i = 0; i <= waits; i++) begin
          v = '0; v.busy = 1; v.mem_read = lw; v.mem_write = sw; seq.push_back(v);
        end
      end
      if (md) for (int i = 0; i < NMD; i++) begin
        v = '0; v.busy = 1; v.hilo_write = (i == NMD - 1); seq.push_back(v);
      end
      if (!md && !sw && op != BEQ_) begin
        v = '0; v.busy = 1; v.reg_write = 1; v.reg_dst = !(op == ADDI_ || lw);
        v.mem_to_reg = lw; seq.push_back(v);
      end
    end
    for (int i = 0; i <= seq.size(); i++) begin
      if (i == abort_at) begin
        step(1, 6'($urandom), 1'($urandom), 1'($urandom), '0);
        return;
      end
      if (i == seq.size()) break;
      step(0, (i == 1) ? op : 6'($urandom), (i == ex) ? z : 1'($urandom),
           (m0 >= 0 && i >= m0 && i <= m1) ? (i == m1) : 1'($urandom), seq[i]);
    end
  endtask

  logic [5:0] ops [15] = '{AND_, OR_, NOR_, ADD_, SUB_, SLT_, ADDI_, DIV_, MULT_, LW_, SW_,
                          MFHI_, MFLO_, BEQ_, J_};

  initial begin
    logic [5:0] o;
    int k, ab;
    step(1, 6'h3f, 1, 1, '0);
    step(1, 6'h00, 0, 0, '0);
    instr(ADD_, 0, 0, -1);
    instr(LW_, 0, 3, -1);
    instr(BEQ_, 1, 0, -1);
    instr(BEQ_, 0, 0, -1);
    instr(MULT_, 0, 0, -1);
    instr(MULT_, 0, 0, 4);
    instr(DIV_, 0, 0, -1);
    instr(6'b111111, 0, 2, -1);
    instr(SLT_, 0, 0, -1);
    instr(SW_, 0, 2, 3);
    instr(MFHI_, 0, 0, -1);
    instr(J_, 0, 0, -1);
    repeat (300) begin
      k = $urandom_range(0, 15);
      if (k == 15) begin
        do o = 6'($urandom); while (legal(o));
      end else o = ops[k];
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      instr(o, 1'($urandom), $urandom_range(0, 4), ab);
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
